// File: rtl/hmc_reset_pkg.sv
// Shared types and constants for the HMC reset sequencer.
// The state encodings are also exported on state_o for debug.
package hmc_reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_CTRL_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4,
    ST_LOCK_ERR  = 3'd5
  } rst_state_e;

  localparam int LOCK_FILTER_LEN = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int FILT_W          = $clog2(LOCK_FILTER_LEN);

endpackage

// File: rtl/hmc_sync_2ff.sv
// Flop-chain synchroniser bringing a single asynchronous level into the local clock domain.
// Uses a synchronous active-low clear.
module hmc_sync_2ff
  import hmc_reset_pkg::*;
(
  input  logic clk,
  input  logic res_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!res_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hmc_reset_sequencer.sv
// Staged reset release for the HMC controller.
// The controller core comes out of reset first, then the user/AXI side follows after a fixed delay.
module hmc_reset_sequencer
  import hmc_reset_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int USER_DELAY   = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk_hmc,
  input  logic       res_n_hmc,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       soft_rst_ack,
  output logic       res_n_ctrl,
  output logic       res_n_user_out,
  output logic       init_done,
  output logic       lock_err,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  USER_LAST    = CNT_W'(USER_DELAY - 1);
  localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(LOCK_FILTER_LEN - 1);

  rst_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [FILT_W-1:0] filt;
  logic              lock_s;

  hmc_sync_2ff u_lock_sync (
    .clk   (clk_hmc),
    .res_n (res_n_hmc),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Outputs are updated on the transition edge itself so they always match the state they accompany.
  always_ff @(posedge clk_hmc) begin
    if (!res_n_hmc) begin
      state          <= ST_HOLD;
      cnt            <= '0;
      filt           <= '0;
      res_n_ctrl     <= 1'b0;
      res_n_user_out <= 1'b0;
      init_done      <= 1'b0;
      lock_err       <= 1'b0;
      soft_rst_ack   <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          filt <= '0;
          if (cnt == HOLD_LAST) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s && (filt == FILT_LAST)) begin
            state      <= ST_CTRL_UP;
            cnt        <= '0;
            filt       <= '0;
            res_n_ctrl <= 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= ST_LOCK_ERR;
            cnt      <= '0;
            filt     <= '0;
            lock_err <= 1'b1;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            filt <= lock_s ? filt + FILT_W'(1) : '0;
          end
        end

        // Losing lock before the user side is released wins over the delay expiring.
        ST_CTRL_UP: begin
          if (!lock_s) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            res_n_ctrl <= 1'b0;
          end else if (cnt == USER_LAST) begin
            state          <= ST_RUN;
            cnt            <= '0;
            res_n_user_out <= 1'b1;
            init_done      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (soft_rst_req) begin
            state          <= ST_SOFT;
            res_n_ctrl     <= 1'b0;
            res_n_user_out <= 1'b0;
            init_done      <= 1'b0;
            soft_rst_ack   <= 1'b1;
          end else if (!lock_s) begin
            state          <= ST_HOLD;
            cnt            <= '0;
            res_n_ctrl     <= 1'b0;
            res_n_user_out <= 1'b0;
            init_done      <= 1'b0;
          end
        end

        ST_SOFT: begin
          if (!soft_rst_req) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            soft_rst_ack <= 1'b0;
          end
        end

        ST_LOCK_ERR: begin
          if (soft_rst_req) begin
            state        <= ST_SOFT;
            lock_err     <= 1'b0;
            soft_rst_ack <= 1'b1;
          end
        end

        default: begin
          state          <= ST_HOLD;
          cnt            <= '0;
          filt           <= '0;
          res_n_ctrl     <= 1'b0;
          res_n_user_out <= 1'b0;
          init_done      <= 1'b0;
          lock_err       <= 1'b0;
          soft_rst_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hmc_reset_sequencer.sv
// Self-checking bench for hmc_reset_sequencer: directed vector table, corner sequences, and a
// randomized run checked every cycle against an elapsed-time reference model.
module tb_hmc_reset_sequencer;

  localparam int HOLD_CYCLES  = 16;
  localparam int LOCK_TIMEOUT = 1024;
  localparam int USER_DELAY   = 8;
  localparam int FILTER_LEN   = 4;
  localparam int MAXE         = 40000;

  localparam int P_HOLD = 0, P_WAIT = 1, P_CTRL = 2, P_RUN = 3, P_SOFT = 4, P_ERR = 5;

  logic       clk_hmc = 1'b0;
  logic       res_n_hmc;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       soft_rst_ack;
  logic       res_n_ctrl;
  logic       res_n_user_out;
  logic       init_done;
  logic       lock_err;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  hmc_reset_sequencer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .USER_DELAY   (USER_DELAY),
    .CNT_W        (16)
  ) dut (
    .clk_hmc        (clk_hmc),
    .res_n_hmc      (res_n_hmc),
    .pll_locked     (pll_locked),
    .soft_rst_req   (soft_rst_req),
    .soft_rst_ack   (soft_rst_ack),
    .res_n_ctrl     (res_n_ctrl),
    .res_n_user_out (res_n_user_out),
    .init_done      (init_done),
    .lock_err       (lock_err),
    .state_o        (state_o)
  );

  always #5 clk_hmc = ~clk_hmc;

  // Reference model: each phase is left after an elapsed edge count or a look-back window on the lock history.
  bit rstn_hist [MAXE];
  bit pll_hist  [MAXE];
  bit lock_hist [MAXE];
  int edge_no     = 0;
  int m_phase     = P_HOLD;
  int m_enter     = 0;
  bit model_valid = 1'b0;

  function automatic bit window_high(int k);
    for (int j = 0; j < FILTER_LEN; j++)
      if (!lock_hist[k-j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] expect_of(int phase);
    logic [2:0] st;
    st = 3'(phase);
    return {st, (phase == P_CTRL || phase == P_RUN), (phase == P_RUN), (phase == P_RUN),
            (phase == P_ERR), (phase == P_SOFT)};
  endfunction

  always @(posedge clk_hmc) begin
    if (edge_no < MAXE) begin
      rstn_hist[edge_no] = res_n_hmc;
      pll_hist[edge_no]  = pll_locked;
      lock_hist[edge_no] = (edge_no >= 2) && rstn_hist[edge_no-1] && rstn_hist[edge_no-2] &&
                           pll_hist[edge_no-2];
      if (!res_n_hmc) begin
        m_phase = P_HOLD;
        m_enter = edge_no;
      end else begin
        case (m_phase)
          P_HOLD: if (edge_no - m_enter == HOLD_CYCLES) begin m_phase = P_WAIT; m_enter = edge_no; end
          P_WAIT: begin
            if (edge_no - m_enter >= FILTER_LEN && window_high(edge_no)) begin
              m_phase = P_CTRL; m_enter = edge_no;
            end else if (edge_no - m_enter == LOCK_TIMEOUT) begin
              m_phase = P_ERR; m_enter = edge_no;
            end
          end
          P_CTRL: begin
            if (!lock_hist[edge_no]) begin m_phase = P_HOLD; m_enter = edge_no; end
            else if (edge_no - m_enter == USER_DELAY) begin m_phase = P_RUN; m_enter = edge_no; end
          end
          P_RUN: begin
            if (soft_rst_req) begin m_phase = P_SOFT; m_enter = edge_no; end
            else if (!lock_hist[edge_no]) begin m_phase = P_HOLD; m_enter = edge_no; end
          end
          P_SOFT: if (!soft_rst_req) begin m_phase = P_HOLD; m_enter = edge_no; end
          default: if (soft_rst_req) begin m_phase = P_SOFT; m_enter = edge_no; end
        endcase
      end
      model_valid = 1'b1;
    end
    edge_no++;
  end

  always @(negedge clk_hmc) begin
    logic [7:0] got, exp_v;
    if (model_valid) begin
      got   = {state_o, res_n_ctrl, res_n_user_out, init_done, lock_err, soft_rst_ack};
      exp_v = expect_of(m_phase);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("[TB] FAIL model edge=%0d: got {state,ctrl,user,init,err,ack}=%b expected %b",
                 edge_no - 1, got, exp_v);
      end
    end
  end

  task automatic applyStimulus(input bit rstn, input bit pll, input bit req, input int cycles);
    res_n_hmc    = rstn;
    pll_locked   = pll;
    soft_rst_req = req;
    repeat (cycles) begin
      @(posedge clk_hmc);
      @(negedge clk_hmc);
    end
  endtask

  task automatic checkOutput(input string name, input int st, input bit ctrl, input bit user,
                             input bit init, input bit err, input bit ack);
    logic [7:0] got, exp_v;
    logic [2:0] st3;
    st3   = 3'(st);
    got   = {state_o, res_n_ctrl, res_n_user_out, init_done, lock_err, soft_rst_ack};
    exp_v = {st3, ctrl, user, init, err, ack};
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got {state,ctrl,user,init,err,ack}=%b expected %b", name, got, exp_v);
    end
  endtask

  typedef struct {
    string name;
    bit    rstn;
    bit    pll;
    bit    req;
    int    cycles;
    int    st;
    bit    ctrl;
    bit    user;
    bit    init;
    bit    err;
    bit    ack;
  } vec_t;

  vec_t vecs [17];

  initial begin
    bit [7:0] pat;

    vecs[0]  = '{"reset",        0, 1, 0, 5,    0, 0, 0, 0, 0, 0};
    vecs[1]  = '{"wait_lock",    1, 1, 0, 19,   1, 0, 0, 0, 0, 0};
    vecs[2]  = '{"ctrl_up",      1, 1, 0, 1,    2, 1, 0, 0, 0, 0};
    vecs[3]  = '{"user_delay",   1, 1, 0, 7,    2, 1, 0, 0, 0, 0};
    vecs[4]  = '{"run",          1, 1, 0, 1,    3, 1, 1, 1, 0, 0};
    vecs[5]  = '{"soft_enter",   1, 1, 1, 1,    4, 0, 0, 0, 0, 1};
    vecs[6]  = '{"soft_hold",    1, 1, 1, 9,    4, 0, 0, 0, 0, 1};
    vecs[7]  = '{"soft_exit",    1, 1, 0, 1,    0, 0, 0, 0, 0, 0};
    vecs[8]  = '{"resequence",   1, 1, 0, 27,   2, 1, 0, 0, 0, 0};
    vecs[9]  = '{"rerun",        1, 1, 0, 1,    3, 1, 1, 1, 0, 0};
    vecs[10] = '{"lock_loss_t1", 1, 0, 0, 2,    3, 1, 1, 1, 0, 0};
    vecs[11] = '{"lock_loss_t2", 1, 0, 0, 1,    0, 0, 0, 0, 0, 0};
    vecs[12] = '{"timeout_pre",  1, 0, 0, 1039, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{"lock_err",     1, 0, 0, 1,    5, 0, 0, 0, 1, 0};
    vecs[14] = '{"err_soft",     1, 0, 1, 1,    4, 0, 0, 0, 0, 1};
    vecs[15] = '{"err_release",  1, 0, 0, 1,    0, 0, 0, 0, 0, 0};
    vecs[16] = '{"restart",      1, 1, 0, 20,   2, 1, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].pll, vecs[i].req, vecs[i].cycles);
      checkOutput(vecs[i].name, vecs[i].st, vecs[i].ctrl, vecs[i].user, vecs[i].init,
                  vecs[i].err, vecs[i].ack);
    end

    // Glitch: lock samples seen in WAIT_LOCK are 1,1,1,0,1,1,1,1 so release must wait for the second run.
    applyStimulus(0, 0, 0, 2);
    applyStimulus(1, 0, 0, 14);
    pat = 8'b1110_1111;
    for (int i = 0; i < 8; i++) applyStimulus(1, pat[7-i], 0, 1);
    checkOutput("glitch_no_early", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("glitch_hold", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("glitch_release", 2, 1, 0, 0, 0, 0);

    applyStimulus(0, 1, 0, 2);
    applyStimulus(1, 1, 0, 22);
    checkOutput("mid_ctrl_pre", 2, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("mid_ctrl_rst", 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 1, 0, 28);
    checkOutput("mid_soft_run", 3, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("mid_soft_pre", 4, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 1);
    checkOutput("mid_soft_rst", 0, 0, 0, 0, 0, 0);

    // Lock loss reaches the FSM on the same edge that first samples the request.
    applyStimulus(1, 1, 0, 28);
    checkOutput("simul_run", 3, 1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 2);
    checkOutput("simul_pre", 3, 1, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 1);
    checkOutput("simul_soft", 4, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("simul_exit", 0, 0, 0, 0, 0, 0);

    for (int s = 0; s < 400 && edge_no < MAXE - 100; s++) begin
      applyStimulus($urandom_range(0, 99) >= 4, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 4) == 0, $urandom_range(1, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hmc_reset_sequencer.md
Name: hmc_reset_sequencer

Overview:
- Generates the staged, ordered reset releases for the HMC controller: the controller core first, then the user/AXI side.
- Sits upstream of the controller's system signals. Its outputs drive the controller-side reset and the user-side reset (`res_n_user`).
- Sequence: hold reset → wait for a filtered PLL lock → release controller → delay → release user side.
- Also handles a 4-phase soft-reset handshake and recovery from loss of lock.

Parameters:
- HOLD_CYCLES, 16, cycles the resets are held after `res_n_hmc` deasserts (≥2).
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before flagging an error (≥8).
- USER_DELAY, 8, cycles between `res_n_ctrl` rising and `res_n_user_out` rising (≥1).
- CNT_W, 16, width of the shared cycle counter; must hold max(HOLD_CYCLES, LOCK_TIMEOUT, USER_DELAY).

Ports:
- clk_hmc  in  1  single clock, rising-edge.
- res_n_hmc  in  1  synchronous, active-low block reset.
- pll_locked  in  1  PLL lock; asynchronous, synchronised internally.
- soft_rst_req  in  1  soft-reset request, level, 4-phase.
- soft_rst_ack  out  1  soft-reset acknowledge.
- res_n_ctrl  out  1  active-low reset to the controller core.
- res_n_user_out  out  1  active-low reset to the user-side logic.
- init_done  out  1  high only in RUN.
- lock_err  out  1  high only in LOCK_ERR.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- One clock (`clk_hmc`). Reset is synchronous and active-low (`res_n_hmc`). All outputs are registered.
- While `res_n_hmc`=0: state=HOLD, cnt=0, lock filter=0, synchroniser flops=0. Outputs: `res_n_ctrl`=0, `res_n_user_out`=0, `init_done`=0, `lock_err`=0, `soft_rst_ack`=0.
- Reset asserted mid-sequence behaves identically: it aborts any state on the next edge.
- `pll_locked` passes through a 2-flop synchroniser giving `lock_s`. `lock_s` is used everywhere below.
- Edge 0 is the first edge that samples `res_n_hmc`=1.

FSM states:
- HOLD (0): both resets low.
  - If cnt==HOLD_CYCLES-1 → WAIT_LOCK with cnt=0; else cnt++.
- WAIT_LOCK (1): both resets low.
  - Filter counter increments when `lock_s`=1 and clears when `lock_s`=0.
  - On the 4th consecutive high sample → CTRL_UP with cnt=0, and `res_n_ctrl`←1 on the same edge.
  - Otherwise, if cnt==LOCK_TIMEOUT-1 → LOCK_ERR; else cnt++.
- CTRL_UP (2): `res_n_ctrl`=1.
  - If cnt==USER_DELAY-1 → RUN, with `res_n_user_out`←1 and `init_done`←1 on the same edge.
  - `lock_s`=0 → HOLD (both resets low, cnt=0).
- RUN (3): both resets high.
  - `soft_rst_req`=1 → SOFT.
  - Else `lock_s`=0 → HOLD.
  - `soft_rst_req` has priority when both occur in the same cycle.
- SOFT (4): both resets low, `soft_rst_ack`=1.
  - Stays until `soft_rst_req`=0, then → HOLD with `soft_rst_ack`←0 and cnt=0.
  - A requester dropping `req` before seeing `ack` is a protocol violation; it is treated as a completed handshake.
- LOCK_ERR (5): both resets low, `lock_err`=1.
  - Exits only via `res_n_hmc`=0 or `soft_rst_req`=1 (→ SOFT, `lock_err`←0).
- `soft_rst_req` in HOLD, WAIT_LOCK or CTRL_UP is ignored until RUN or LOCK_ERR.
- Timing with `pll_locked` constantly high and default parameters:
  - `res_n_ctrl` rises after edge 19 (HOLD_CYCLES+3).
  - `res_n_user_out` and `init_done` rise after edge 27 (HOLD_CYCLES+3+USER_DELAY).
- Lock loss in RUN: if `pll_locked` is first sampled low at edge t, both resets fall after edge t+2.
- The counter never wraps: every state exits at its terminal count.

Decomposition:
- Package hmc_reset_pkg:
  - State enum `rst_state_e`, 3 bits, encodings as listed above.
  - LOCK_FILTER_LEN=4.
  - SYNC_STAGES=2.
- Sub-module hmc_sync_2ff: generic 1-bit 2-flop synchroniser with synchronous active-low reset, instantiated for `pll_locked`.

Test Plan:
- Nominal bring-up:
  - Stimulus: `res_n_hmc` low for 5 cycles then high; `pll_locked`=1; defaults.
  - Required: `res_n_ctrl` rises after edge 19; `res_n_user_out` and `init_done` rise after edge 27; `state_o` sequence 0→1→2→3.
- Lock timeout:
  - Stimulus: `pll_locked`=0 throughout.
  - Required: `lock_err` rises after edge 1039; resets stay low.
  - Follow-up: `soft_rst_req` pulse-handshake → `lock_err` clears, sequence restarts from HOLD.
- Lock glitch filtering:
  - Stimulus: `pll_locked` pattern 1,1,1,0,1,1,1,1 at WAIT_LOCK entry.
  - Required: `res_n_ctrl` rises only after the 4-high run completes (filter restart); no early release.
- Soft reset in RUN:
  - Stimulus: raise `soft_rst_req`; hold 10 cycles; drop.
  - Required: `soft_rst_ack`=1 and both resets low one edge after `req` is sampled; `ack` drops one edge after `req` falls; full re-sequence; `init_done` returns 27 edges later.
- Lock loss in RUN, plus simultaneous event:
  - Stimulus: `pll_locked` drops at edge t.
  - Required: both resets low after edge t+2.
  - Simultaneous case: `soft_rst_req` and lock loss in the same cycle → state 4 (SOFT), `soft_rst_ack`=1.
- Reset mid-operation:
  - Stimulus: `res_n_hmc` low in CTRL_UP and in SOFT.
  - Required: next edge gives state 0 with all outputs 0, including `soft_rst_ack` and `lock_err`.
